// File: rtl/jamma_input_scan.sv
// jamma_input_scan
// Time-multiplexed JAMMA control scanner. Alternates the player-select line,
// samples the shared joystick bus once per player phase, merges the local DB9
// joystick into player 1, debounces every bit and stretches coin pulses.
// All outputs are active-low except coin and scan_tick. Synchronous active-low reset.

module jamma_input_scan #(
    parameter int SCAN_DIV   = 32,
    parameter int SETTLE     = 4,
    parameter int DEBOUNCE_N = 4,
    parameter int COIN_MIN   = 3
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic [7:0] jjoy,
    input  logic [1:0] jcoin,
    input  logic [5:0] joystick_local,
    output logic       jselect,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic [1:0] coin,
    output logic       scan_tick
);

    localparam int CW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DBW = $clog2(DEBOUNCE_N + 1);
    localparam int SW  = $clog2(COIN_MIN + 1);
    localparam int NB  = 18;  // joy1[7:0], joy2[15:8], coin_db[17:16]

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } state_t;

    // Synchronizer stages (first and second flop)
    logic [7:0]     jjoy_s1_r, jjoy_s2_r;
    logic [1:0]     jcoin_s1_r, jcoin_s2_r;
    logic [5:0]     local_s1_r, local_s2_r;

    // Phase sequencing
    logic [CW-1:0]  cnt_r, cnt_nxt_s;
    logic           wrap_s;
    state_t         state_r, state_nxt_s;
    logic           samp_p1_s, samp_p2_s;
    logic           scan_tick_r, scan_tick_nxt_s;

    // Debounce state: one output bit and one counter per bit
    logic [NB-1:0]  db_out_r, db_out_nxt_s;
    logic [DBW-1:0] db_cnt_r     [NB];
    logic [DBW-1:0] db_cnt_nxt_s [NB];
    logic [NB-1:0]  samp_s;
    logic [NB-1:0]  en_s;

    // Coin stretch
    logic [SW-1:0]  stretch_r     [2];
    logic [SW-1:0]  stretch_nxt_s [2];
    logic [1:0]     coin_r, coin_nxt_s;

    // Two-flop synchronizers; all-ones at reset so nothing looks pressed
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            jjoy_s1_r  <= 8'hFF;
            jjoy_s2_r  <= 8'hFF;
            jcoin_s1_r <= 2'b11;
            jcoin_s2_r <= 2'b11;
            local_s1_r <= 6'h3F;
            local_s2_r <= 6'h3F;
        end else begin
            jjoy_s1_r  <= jjoy;
            jjoy_s2_r  <= jjoy_s1_r;
            jcoin_s1_r <= jcoin;
            jcoin_s2_r <= jcoin_s1_r;
            local_s1_r <= joystick_local;
            local_s2_r <= local_s1_r;
        end
    end

    // Phase counter next value: wraps at SCAN_DIV-1
    always_comb begin
        wrap_s = (cnt_r == CW'(SCAN_DIV - 1));
        if (wrap_s) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
        end
    end

    // Player-phase state register plus phase counter
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_r <= P1;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: swap player on every phase wrap
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            P1:      state_nxt_s = wrap_s ? P2 : P1;
            P2:      state_nxt_s = wrap_s ? P1 : P2;
            default: state_nxt_s = P1;
        endcase
    end

    // Output decode: sample strobes per phase and look-ahead for the tick register
    always_comb begin
        samp_p1_s       = 1'b0;
        samp_p2_s       = 1'b0;
        scan_tick_nxt_s = 1'b0;
        case (state_r)
            P1:      samp_p1_s = (cnt_r == CW'(SETTLE));
            P2:      samp_p2_s = (cnt_r == CW'(SETTLE));
            default: samp_p1_s = 1'b0;
        endcase
        if ((state_nxt_s == P2) && (cnt_nxt_s == CW'(SETTLE))) begin
            scan_tick_nxt_s = 1'b1;
        end else begin
            scan_tick_nxt_s = 1'b0;
        end
    end

    // Debounce next-state: change an output only after DEBOUNCE_N differing samples
    always_comb begin
        samp_s       = {jcoin_s2_r, jjoy_s2_r, jjoy_s2_r & {2'b11, local_s2_r}};
        en_s         = {{2{samp_p1_s}}, {8{samp_p2_s}}, {8{samp_p1_s}}};
        db_out_nxt_s = db_out_r;
        db_cnt_nxt_s = db_cnt_r;
        for (int i = 0; i < NB; i++) begin
            if (!en_s[i]) begin
                db_cnt_nxt_s[i] = db_cnt_r[i];
            end else if (samp_s[i] == db_out_r[i]) begin
                db_cnt_nxt_s[i] = '0;
            end else if (db_cnt_r[i] == DBW'(DEBOUNCE_N - 1)) begin
                db_out_nxt_s[i] = samp_s[i];
                db_cnt_nxt_s[i] = '0;
            end else begin
                db_cnt_nxt_s[i] = db_cnt_r[i] + DBW'(1);
            end
        end
    end

    // Coin stretch next-state: load on debounced press, count down on scan_tick
    always_comb begin
        stretch_nxt_s = stretch_r;
        coin_nxt_s    = 2'b00;
        for (int c = 0; c < 2; c++) begin
            if (db_out_r[16 + c] && !db_out_nxt_s[16 + c]) begin
                stretch_nxt_s[c] = SW'(COIN_MIN);
            end else if (scan_tick_r && (stretch_r[c] != '0)) begin
                stretch_nxt_s[c] = stretch_r[c] - SW'(1);
            end else begin
                stretch_nxt_s[c] = stretch_r[c];
            end
            coin_nxt_s[c] = (stretch_nxt_s[c] != '0) | ~db_out_nxt_s[16 + c];
        end
    end

    // Debounce, stretch and registered output state
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            db_out_r    <= {NB{1'b1}};
            for (int i = 0; i < NB; i++) begin
                db_cnt_r[i] <= '0;
            end
            stretch_r[0] <= '0;
            stretch_r[1] <= '0;
            coin_r       <= 2'b00;
            scan_tick_r  <= 1'b0;
        end else begin
            db_out_r     <= db_out_nxt_s;
            db_cnt_r     <= db_cnt_nxt_s;
            stretch_r    <= stretch_nxt_s;
            coin_r       <= coin_nxt_s;
            scan_tick_r  <= scan_tick_nxt_s;
        end
    end

    assign jselect   = state_r;
    assign joy1      = db_out_r[7:0];
    assign joy2      = db_out_r[15:8];
    assign coin      = coin_r;
    assign scan_tick = scan_tick_r;

endmodule

// File: tb/tb_jamma_input_scan.sv
// Self-checking bench for jamma_input_scan (COIN_MIN overridden to 8).
// The player bus is modelled as two per-player values muxed by jselect.

module tb_jamma_input_scan;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic [7:0] p1_val, p2_val;
    logic [7:0] jjoy;
    logic [1:0] jcoin;
    logic [5:0] joystick_local;
    logic       jselect;
    logic [7:0] joy1, joy2;
    logic [1:0] coin;
    logic       scan_tick;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] p1;
        logic [7:0] p2;
        logic [5:0] loc;
        int         frames;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t tbl [12];

    always #5 clk_sys = ~clk_sys;

    assign jjoy = jselect ? p2_val : p1_val;

    jamma_input_scan #(
        .SCAN_DIV   (32),
        .SETTLE     (4),
        .DEBOUNCE_N (4),
        .COIN_MIN   (8)
    ) dut (
        .clk_sys        (clk_sys),
        .rst_n          (rst_n),
        .jjoy           (jjoy),
        .jcoin          (jcoin),
        .joystick_local (joystick_local),
        .jselect        (jselect),
        .joy1           (joy1),
        .joy2           (joy2),
        .coin           (coin),
        .scan_tick      (scan_tick)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!scan_tick && n < 200);
        if (!scan_tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: no scan_tick within %0d cycles", n);
        end
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int rise1, rise2, tick1, nticks, high_cycles, ticks_high, coin1_seen;
        logic prev_sel;
        logic released;

        // p1, p2, local, frames, exp joy1, exp joy2
        tbl[0]  = '{8'hFE, 8'hFE, 6'h3F, 3, 8'hFF, 8'hFF};
        tbl[1]  = '{8'hFF, 8'hFF, 6'h3F, 1, 8'hFF, 8'hFF};
        tbl[2]  = '{8'hFE, 8'hFE, 6'h3F, 3, 8'hFF, 8'hFF};
        tbl[3]  = '{8'hFF, 8'hFF, 6'h3F, 1, 8'hFF, 8'hFF};
        tbl[4]  = '{8'hFE, 8'hFF, 6'h3F, 4, 8'hFE, 8'hFF};
        tbl[5]  = '{8'hFF, 8'hFF, 6'h2F, 4, 8'hEF, 8'hFF};
        tbl[6]  = '{8'hFF, 8'h7E, 6'h3F, 4, 8'hFF, 8'h7E};
        tbl[7]  = '{8'h00, 8'h00, 6'h3F, 4, 8'h00, 8'h00};
        tbl[8]  = '{8'h3F, 8'hFF, 6'h00, 2, 8'h00, 8'h00};
        tbl[9]  = '{8'h3F, 8'hFF, 6'h00, 2, 8'h00, 8'hFF};
        tbl[10] = '{8'hFF, 8'hFF, 6'h15, 4, 8'hD5, 8'hFF};
        tbl[11] = '{8'hFF, 8'hFF, 6'h3F, 4, 8'hFF, 8'hFF};

        p1_val = 8'hFF;
        p2_val = 8'hFF;
        jcoin = 2'b11;
        joystick_local = 6'h3F;
        rst_n = 1'b0;

        // Reset values and free-run timing
        repeat (5) step();
        check8("rst_jselect", {7'd0, jselect}, 8'h00);
        check8("rst_joy1", joy1, 8'hFF);
        check8("rst_joy2", joy2, 8'hFF);
        check8("rst_coin", {6'd0, coin}, 8'h00);
        check8("rst_tick", {7'd0, scan_tick}, 8'h00);
        rst_n = 1'b1;
        rise1 = -1; rise2 = -1; tick1 = -1; nticks = 0;
        prev_sel = 1'b0;
        for (int cyc = 1; cyc <= 99; cyc++) begin
            step();
            if (jselect && !prev_sel) begin
                if (rise1 < 0) rise1 = cyc;
                else if (rise2 < 0) rise2 = cyc;
            end
            if (scan_tick) begin
                nticks++;
                if (tick1 < 0) tick1 = cyc;
            end
            prev_sel = jselect;
        end
        check_int("first_jselect_rise", rise1, 32);
        check_int("first_scan_tick", tick1, 36);
        check_int("jselect_period", rise2 - rise1, 64);
        check_int("ticks_in_99", nticks, 1);

        // Table: inputs change right after a scan_tick, checked after N frames
        wait_tick();
        for (int v = 0; v < 12; v++) begin
            p1_val = tbl[v].p1;
            p2_val = tbl[v].p2;
            joystick_local = tbl[v].loc;
            for (int f = 0; f < tbl[v].frames; f++) wait_tick();
            step();
            check8($sformatf("vec%0d_joy1", v), joy1, tbl[v].e1);
            check8($sformatf("vec%0d_joy2", v), joy2, tbl[v].e2);
            check8($sformatf("vec%0d_coin", v), {6'd0, coin}, 8'h00);
        end

        // Exact update cycle: joy1 changes one cycle after the 4th P1 sample
        p1_val = 8'hFF; p2_val = 8'hFF; joystick_local = 6'h3F;
        apply_reset(2);
        wait_tick();
        p1_val = 8'hFE;
        repeat (3) wait_tick();
        repeat (32) step();
        check8("p1_sample_cycle_joy1", joy1, 8'hFF);
        check8("p1_sample_cycle_sel", {7'd0, jselect}, 8'h00);
        step();
        check8("p1_after_sample_joy1", joy1, 8'hFE);
        check8("p1_after_sample_joy2", joy2, 8'hFF);

        // Coin stretch with COIN_MIN = 8
        p1_val = 8'hFF;
        apply_reset(2);
        wait_tick();
        jcoin = 2'b10;
        repeat (3) wait_tick();
        repeat (32) step();
        check8("coin_before_rise", {6'd0, coin}, 8'h00);
        step();
        check8("coin_rise", {6'd0, coin}, 8'h01);
        high_cycles = 1; ticks_high = 0; coin1_seen = 0; released = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            step();
            if (!coin[0]) break;
            high_cycles++;
            if (coin[1]) coin1_seen++;
            if (scan_tick) begin
                ticks_high++;
                if (!released) begin
                    jcoin = 2'b11;
                    released = 1'b1;
                end
            end
        end
        check_int("coin_high_cycles", high_cycles, 480);
        check_int("coin_ticks_high", ticks_high, 8);
        check_int("coin1_seen", coin1_seen, 0);
        repeat (2) wait_tick();
        check8("coin_idle", {6'd0, coin}, 8'h00);

        // Reset mid-debounce clears the pending counts
        apply_reset(2);
        p1_val = 8'h00; p2_val = 8'h00;
        repeat (3) wait_tick();
        step();
        check8("pre_rst_joy1", joy1, 8'hFF);
        check8("pre_rst_joy2", joy2, 8'hFF);
        apply_reset(1);
        check8("mid_rst_joy1", joy1, 8'hFF);
        repeat (3) wait_tick();
        step();
        check8("post_rst3_joy1", joy1, 8'hFF);
        check8("post_rst3_joy2", joy2, 8'hFF);
        wait_tick();
        step();
        check8("post_rst4_joy1", joy1, 8'h00);
        check8("post_rst4_joy2", joy2, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
